// File: rtl/digit_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_mux
// Purpose  : Time-multiplexed scan driver for a 4-digit display. A prescaler
//            divides the clock into digit slots; each slot presents one nibble
//            of the displayed (shadow) value with its active-low enable.
//            New values are staged and committed only at the frame boundary
//            (end of digit 3), so a frame never shows a mix of two values.
//            Optional leading-zero suppression blanks upper zero digits.
// Ports    : JM1222HM_clk      - clock, rising edge
//            JM1222HM_rst_n    - asynchronous active-low reset
//            JM1222HM_load     - capture JM1222HM_value
//            JM1222HM_value    - four nibbles, [3:0] = digit 0 (rightmost)
//            JM1222HM_blank_lz - leading-zero suppression enable
//            JM1222HM_nibble   - code of the active digit
//            JM1222HM_an       - active-low digit enables, bit i = digit i
//            JM1222HM_blank    - active digit is suppressed
//            JM1222HM_pending  - a loaded value is waiting for the boundary
// Revision : 1.0 - initial release
// ============================================================================
module digit_scan_mux #(
  parameter int PRESCALE = 50000
) (
  input  logic        JM1222HM_clk,
  input  logic        JM1222HM_rst_n,
  input  logic        JM1222HM_load,
  input  logic [15:0] JM1222HM_value,
  input  logic        JM1222HM_blank_lz,
  output logic [3:0]  JM1222HM_nibble,
  output logic [3:0]  JM1222HM_an,
  output logic        JM1222HM_blank,
  output logic        JM1222HM_pending
);

  // 20 bits covers the full legal PRESCALE range (last count 2^20-1).
  localparam int                 c_cnt_w    = 20;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(PRESCALE - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_idx;
  logic [15:0]        r_shadow;
  logic [15:0]        r_staging;
  logic               r_pending;
  logic [3:0]         r_nibble;
  logic [3:0]         r_an;
  logic               r_blank;

  logic               w_wrap;
  logic               w_boundary;
  logic [1:0]         w_idx_next;
  logic [15:0]        w_shadow_next;
  logic [3:0]         w_nibble_next;
  logic [3:0]         w_lz;
  logic               w_blank_next;
  logic [3:0]         w_an_next;

  assign w_wrap     = (r_cnt == c_cnt_last);
  assign w_boundary = w_wrap && (r_idx == 2'd3);
  assign w_idx_next = r_idx + 2'd1;

  // Value the shadow will hold after this edge; the display outputs are
  // computed from it so a commit is visible on the very edge it happens.
  always_comb begin
    w_shadow_next = r_shadow;
    if (w_boundary) begin
      if (JM1222HM_load) begin
        w_shadow_next = JM1222HM_value;
      end else if (r_pending) begin
        w_shadow_next = r_staging;
      end
    end
  end

  always_comb begin
    w_nibble_next = w_shadow_next[3:0];
    case (w_idx_next)
      2'd0: w_nibble_next = w_shadow_next[3:0];
      2'd1: w_nibble_next = w_shadow_next[7:4];
      2'd2: w_nibble_next = w_shadow_next[11:8];
      2'd3: w_nibble_next = w_shadow_next[15:12];
      default: w_nibble_next = w_shadow_next[3:0];
    endcase
  end

  // w_lz[i]: nibbles i..3 are all zero. Digit 0 is never a leading zero.
  assign w_lz[3] = (w_shadow_next[15:12] == 4'h0);
  assign w_lz[2] = w_lz[3] && (w_shadow_next[11:8] == 4'h0);
  assign w_lz[1] = w_lz[2] && (w_shadow_next[7:4] == 4'h0);
  assign w_lz[0] = 1'b0;

  assign w_blank_next = JM1222HM_blank_lz && w_lz[w_idx_next];
  assign w_an_next    = w_blank_next ? 4'b1111 : ~(4'b0001 << w_idx_next);

  always_ff @(posedge JM1222HM_clk or negedge JM1222HM_rst_n) begin
    if (!JM1222HM_rst_n) begin
      r_cnt     <= '0;
      r_idx     <= 2'd0;
      r_shadow  <= 16'h0000;
      r_staging <= 16'h0000;
      r_pending <= 1'b0;
      r_nibble  <= 4'h0;
      r_an      <= 4'b1110;
      r_blank   <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + c_cnt_w'(1);

      if (w_wrap) begin
        r_idx    <= w_idx_next;
        r_nibble <= w_nibble_next;
        r_an     <= w_an_next;
        r_blank  <= w_blank_next;
      end

      // A load on the boundary bypasses staging; otherwise it overwrites
      // staging so only the most recent value survives to the commit.
      if (JM1222HM_load && !w_boundary) begin
        r_staging <= JM1222HM_value;
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_shadow  <= w_shadow_next;
        r_pending <= 1'b0;
      end
    end
  end

  assign JM1222HM_nibble  = r_nibble;
  assign JM1222HM_an      = r_an;
  assign JM1222HM_blank   = r_blank;
  assign JM1222HM_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_scan_mux
// Purpose  : Directed self-checking bench for digit_scan_mux with PRESCALE=4.
//            Edge counter e counts rising edges since the last reset release;
//            wrap edges fall on multiples of 4, frame boundaries on multiples
//            of 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_scan_mux;

  localparam int c_prescale = 4;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        blank;
  logic        pending;

  int n_vec  = 0;
  int n_miss = 0;
  int e      = 0;

  digit_scan_mux #(.PRESCALE(c_prescale)) u_dut (
    .JM1222HM_clk      (clk),
    .JM1222HM_rst_n    (rst_n),
    .JM1222HM_load     (load),
    .JM1222HM_value    (value),
    .JM1222HM_blank_lz (blank_lz),
    .JM1222HM_nibble   (nibble),
    .JM1222HM_an       (an),
    .JM1222HM_blank    (blank),
    .JM1222HM_pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (e=%0d)", tag, got, exp, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (e < target && guard < 1000) begin
      tick();
      guard++;
    end
  endtask

  task automatic check_disp(input string tag, input logic [3:0] exp_an,
                            input logic [3:0] exp_nib, input logic exp_blank);
    check_val({tag, ".an"},     16'(an),     16'(exp_an));
    check_val({tag, ".nibble"}, 16'(nibble), 16'(exp_nib));
    check_val({tag, ".blank"},  16'(blank),  16'(exp_blank));
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = 16'h0000;
    blank_lz = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_disp("rst", 4'b1110, 4'h0, 1'b0);
    check_val("rst.pending", 16'(pending), 16'h0);
    rst_n = 1'b1;
    e     = 0;

    // Outputs hold until the first wrap on edge 4
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_disp("hold", 4'b1110, 4'h0, 1'b0);
    end
    tick();
    check_disp("first_wrap", 4'b1101, 4'h0, 1'b0);

    // Scan 1234 loaded mid-frame (edge 5), committed at edge 16
    load = 1'b1; value = 16'h1234;
    tick();
    load = 1'b0;
    check_val("scan.pend_set", 16'(pending), 16'h1);
    run_to(15);
    check_val("scan.pend_hold", 16'(pending), 16'h1);
    check_val("scan.old_nib", 16'(nibble), 16'h0);
    tick();
    check_val("scan.pend_clr", 16'(pending), 16'h0);
    check_disp("scan.d0", 4'b1110, 4'h4, 1'b0);
    run_to(19);
    check_disp("scan.d0_held", 4'b1110, 4'h4, 1'b0);
    run_to(20); check_disp("scan.d1", 4'b1101, 4'h3, 1'b0);
    run_to(24); check_disp("scan.d2", 4'b1011, 4'h2, 1'b0);
    run_to(28); check_disp("scan.d3", 4'b0111, 4'h1, 1'b0);
    run_to(32); check_disp("scan.rep", 4'b1110, 4'h4, 1'b0);

    // Reset mid digit 2 with a value pending
    run_to(40);
    check_disp("pre_rst.d2", 4'b1011, 4'h2, 1'b0);
    load = 1'b1; value = 16'h5555;
    tick();
    load = 1'b0;
    check_val("pre_rst.pend", 16'(pending), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_disp("async_rst", 4'b1110, 4'h0, 1'b0);
    check_val("async_rst.pend", 16'(pending), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e     = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_disp("rst2.hold", 4'b1110, 4'h0, 1'b0);
    end
    tick();
    check_disp("rst2.wrap", 4'b1101, 4'h0, 1'b0);
    run_to(16);
    check_disp("rst2.discard", 4'b1110, 4'h0, 1'b0);
    check_val("rst2.pend", 16'(pending), 16'h0);

    // Leading-zero suppression on 0050
    blank_lz = 1'b1;
    load = 1'b1; value = 16'h0050;
    tick();
    load = 1'b0;
    run_to(32); check_disp("lz50.d0", 4'b1110, 4'h0, 1'b0);
    run_to(36); check_disp("lz50.d1", 4'b1101, 4'h5, 1'b0);
    run_to(40); check_disp("lz50.d2", 4'b1111, 4'h0, 1'b1);
    run_to(44); check_disp("lz50.d3", 4'b1111, 4'h0, 1'b1);

    // Suppression on 0000: only digit 0 enabled
    run_to(48);
    load = 1'b1; value = 16'h0000;
    tick();
    load = 1'b0;
    run_to(64); check_disp("lz00.d0", 4'b1110, 4'h0, 1'b0);
    run_to(68); check_disp("lz00.d1", 4'b1111, 4'h0, 1'b1);
    run_to(72); check_disp("lz00.d2", 4'b1111, 4'h0, 1'b1);
    run_to(76); check_disp("lz00.d3", 4'b1111, 4'h0, 1'b1);

    // Last load wins: AAAA at edge 81, BBBB at edge 85
    run_to(80);
    load = 1'b1; value = 16'hAAAA;
    tick();
    load = 1'b0;
    run_to(84);
    load = 1'b1; value = 16'hBBBB;
    tick();
    load = 1'b0;
    while (e < 95) begin
      check_val("lw.pend", 16'(pending), 16'h1);
      check_val("lw.nib", 16'(nibble), 16'h0);
      tick();
    end
    check_val("lw.pend95", 16'(pending), 16'h1);
    tick();
    check_val("lw.pend_clr", 16'(pending), 16'h0);
    check_disp("lw.d0", 4'b1110, 4'hB, 1'b0);
    run_to(100); check_disp("lw.d1", 4'b1101, 4'hB, 1'b0);

    // Coincident load of 9876 on the boundary edge 112
    run_to(111);
    load = 1'b1; value = 16'h9876;
    tick();
    load = 1'b0;
    check_val("coin.pend", 16'(pending), 16'h0);
    check_disp("coin.d0", 4'b1110, 4'h6, 1'b0);
    run_to(116); check_disp("coin.d1", 4'b1101, 4'h7, 1'b0);
    run_to(124); check_disp("coin.d3", 4'b0111, 4'h9, 1'b0);

    // Coincident load overrides a pending value; non-BCD digits FEDC
    load = 1'b1; value = 16'h1111;
    tick();
    load = 1'b0;
    check_val("nb.pend_set", 16'(pending), 16'h1);
    run_to(127);
    load = 1'b1; value = 16'hFEDC;
    tick();
    load = 1'b0;
    check_val("nb.pend_clr", 16'(pending), 16'h0);
    check_disp("nb.d0", 4'b1110, 4'hC, 1'b0);
    run_to(132); check_disp("nb.d1", 4'b1101, 4'hD, 1'b0);
    run_to(136); check_disp("nb.d2", 4'b1011, 4'hE, 1'b0);
    run_to(140); check_disp("nb.d3", 4'b0111, 4'hF, 1'b0);
    run_to(144); check_disp("nb.rep", 4'b1110, 4'hC, 1'b0);
    check_val("nb.pend_end", 16'(pending), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
